seq_alu: RTL and testbench

Parametrised, handshaked, multi-cycle ALU that succeeds the fixed 4-bit combinational ALU and keeps its opcode map. It takes W-bit operands rs1, rs2 and rs3, and produces a 2W-bit result with 4 status flags. Multiply-class ops use an iterative shift-add datapath, one multiplier bit per cycle. The block sits between the operand-fetch stage and writeback, with valid/ready on both sides and one operation in flight.

---
 rtl/seq_alu.sv | 188 ++++++++++++++++++
 tb/tb_seq_alu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle logic/add/sub ops plus an iterative
// shift-add multiplier with optional rs3 accumulate. One operation in flight at a time.
module seq_alu #(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [W-1:0]     rs1,
   input  logic [W-1:0]     rs2,
   input  logic [W-1:0]     rs3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   result,
   output logic [3:0]       status
);

   localparam int RW = 2 * W;
   localparam int CW = $clog2(W);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] ACC  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [3:0] OP_NOT = 4'b0000;
   localparam logic [3:0] OP_NEG = 4'b1010;
   localparam logic [3:0] OP_SRL = 4'b1000;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_PAR = 4'b1001;
   localparam logic [3:0] OP_ADD = 4'b1011;
   localparam logic [3:0] OP_SUB = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b1101;
   localparam logic [3:0] OP_MAD = 4'b1110;
   localparam logic [3:0] OP_MSB = 4'b1111;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   function automatic logic even_parity(input logic [W-1:0] v);
      return ^v;
   endfunction

   function automatic logic [3:0] make_status(input logic [RW-1:0] r, input logic c, input logic e);
      return {(r == {RW{1'b0}}), r[RW-1], c, e};
   endfunction

   logic [1:0]    state_r;
   logic [3:0]    op_r;
   logic [W-1:0]  c_r;
   logic [W-1:0]  mplier_r;
   logic [RW-1:0] mcand_r;
   logic [RW-1:0] acc_r;
   logic [CW-1:0] cnt_r;
   logic [RW-1:0] result_r;
   logic [3:0]    status_r;
   logic          in_ready_r;
   logic          out_valid_r;

   logic [RW-1:0] simple_res_s;
   logic          simple_c_s;
   logic          simple_e_s;
   logic          mul_op_s;
   logic [RW-1:0] add_s;
   logic [RW-1:0] sub_s;
   logic [W-1:0]  neg_s;
   logic [W-1:0]  x_s;
   logic [RW-1:0] acc_step_s;
   logic [RW:0]   acc_ext_s;

   assign add_s = {{W{1'b0}}, rs1} + {{W{1'b0}}, rs2};
   assign sub_s = {{W{1'b0}}, rs1} - {{W{1'b0}}, rs2};
   assign neg_s = (~rs1) + {{(W-1){1'b0}}, 1'b1};
   assign x_s   = rs2 ^ rs3;

   assign acc_step_s = acc_r + (mplier_r[0] ? mcand_r : {RW{1'b0}});
   // Bit RW of the extended sum is the carry for multiply-add and the borrow for multiply-subtract.
   assign acc_ext_s  = (op_r == OP_MAD) ? ({1'b0, acc_r} + {{(W+1){1'b0}}, c_r})
                                        : ({1'b0, acc_r} - {{(W+1){1'b0}}, c_r});

   // Single-cycle result and flags for the operands presented at the accept edge.
   always_comb begin
      simple_res_s = {RW{1'b0}};
      simple_c_s   = 1'b0;
      simple_e_s   = 1'b0;
      mul_op_s     = 1'b0;
      case (op)
         OP_NOT: simple_res_s = {{W{1'b0}}, ~rs1};
         OP_NEG: simple_res_s = {{W{1'b0}}, neg_s};
         OP_SRL: simple_res_s = {{W{1'b0}}, rs1 >> 1'b1};
         OP_XOR: simple_res_s = {{W{1'b0}}, x_s};
         OP_PAR: simple_res_s = {{(RW-1){1'b0}}, even_parity(x_s)};
         OP_ADD: begin
            simple_res_s = add_s;
            simple_c_s   = add_s[W];
         end
         OP_SUB: begin
            simple_res_s = sub_s;
            simple_c_s   = (rs1 < rs2);
         end
         OP_MUL, OP_MAD, OP_MSB: mul_op_s = 1'b1;
         default: simple_e_s = 1'b1;
      endcase
   end

   // Control FSM, shift-add datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         op_r        <= 4'b0000;
         c_r         <= {W{1'b0}};
         mplier_r    <= {W{1'b0}};
         mcand_r     <= {RW{1'b0}};
         acc_r       <= {RW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         result_r    <= {RW{1'b0}};
         status_r    <= 4'b0000;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  op_r       <= op;
                  c_r        <= rs3;
                  in_ready_r <= 1'b0;
                  if (mul_op_s) begin
                     // Multiplier bit 0 is folded into the accept edge so a multiply takes W edges.
                     state_r  <= MUL;
                     acc_r    <= rs2[0] ? {{W{1'b0}}, rs1} : {RW{1'b0}};
                     mcand_r  <= {{(W-1){1'b0}}, rs1, 1'b0};
                     mplier_r <= rs2 >> 1'b1;
                     cnt_r    <= CNT_ONE;
                  end else begin
                     state_r     <= DONE;
                     result_r    <= simple_res_s;
                     status_r    <= make_status(simple_res_s, simple_c_s, simple_e_s);
                     out_valid_r <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc_r    <= acc_step_s;
               mcand_r  <= mcand_r << 1'b1;
               mplier_r <= mplier_r >> 1'b1;
               cnt_r    <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  if (op_r == OP_MUL) begin
                     state_r     <= DONE;
                     result_r    <= acc_step_s;
                     status_r    <= make_status(acc_step_s, 1'b0, 1'b0);
                     out_valid_r <= 1'b1;
                  end else begin
                     state_r <= ACC;
                  end
               end
            end
            ACC: begin
               acc_r       <= acc_ext_s[RW-1:0];
               result_r    <= acc_ext_s[RW-1:0];
               status_r    <= make_status(acc_ext_s[RW-1:0], acc_ext_s[RW], 1'b0);
               state_r     <= DONE;
               out_valid_r <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign status    = status_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (W=4): directed vector table, handshake and
// reset corner sequences, then random operations against an arithmetic reference model.
module tb_seq_alu;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] rs1, rs2, rs3;
   logic         out_valid;
   logic         out_ready;
   logic [2*W-1:0] result;
   logic [3:0]   status;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] c;
      logic [7:0] res;
      logic [3:0] st;
      int         lat;
   } vec_t;

   vec_t tbl [16];

   seq_alu #(.W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .rs1(rs1), .rs2(rs2), .rs3(rs3), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .status(status)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the opcode rules, W=4 so results are mod 256.
   function automatic void model(input logic [3:0] o, input int a, input int b, input int c,
                                 output logic [7:0] r, output logic [3:0] st, output int lat);
      int v;
      bit cf, ef;
      v = 0; cf = 1'b0; ef = 1'b0; lat = 1;
      case (o)
         4'b0000: v = 15 - a;
         4'b1010: v = (16 - a) % 16;
         4'b1000: v = a / 2;
         4'b0111: v = b ^ c;
         4'b1001: v = $countones(b ^ c) % 2;
         4'b1011: begin v = a + b; cf = (v >= 16); end
         4'b1100: begin v = (a - b + 256) % 256; cf = (a < b); end
         4'b1101: begin v = a * b; lat = W; end
         4'b1110: begin v = (a * b + c) % 256; cf = (a * b + c >= 256); lat = W + 1; end
         4'b1111: begin v = (a * b - c + 256) % 256; cf = (a * b < c); lat = W + 1; end
         default: begin v = 0; ef = 1'b1; end
      endcase
      r  = 8'(v);
      st = {(v == 0), (v >= 128), cf, ef};
   endfunction

   task automatic do_op(input string name, input logic [3:0] o, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c, input logic [7:0] er,
                        input logic [3:0] es, input int elat, input int hold);
      int lat;
      @(negedge clk);
      check({name, "/ready_before"}, 32'(in_ready), 32'd1);
      op = o; rs1 = a; rs2 = b; rs3 = c; in_valid = 1'b1;
      @(posedge clk); #1;
      // Scramble inputs after the accept edge; the operation in flight must not see them.
      in_valid = 1'b0;
      op  = 4'($urandom_range(15));
      rs1 = 4'($urandom_range(15));
      rs2 = 4'($urandom_range(15));
      rs3 = 4'($urandom_range(15));
      lat = 1;
      while (!out_valid && lat < 4 * W) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "/latency"}, 32'(lat), 32'(elat));
      check({name, "/result"}, 32'(result), 32'(er));
      check({name, "/status"}, 32'(status), 32'(es));
      check({name, "/ready_done"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, "/hold_valid"}, 32'(out_valid), 32'd1);
         check({name, "/hold_result"}, 32'(result), 32'(er));
         check({name, "/hold_status"}, 32'(status), 32'(es));
         check({name, "/hold_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "/valid_after"}, 32'(out_valid), 32'd0);
      check({name, "/ready_after"}, 32'(in_ready), 32'd1);
      check({name, "/result_kept"}, 32'(result), 32'(er));
   endtask

   initial begin
      logic [3:0] ro, ra, rb, rc;
      logic [7:0] mr;
      logic [3:0] ms;
      int         ml;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = 4'd0; rs1 = 4'd0; rs2 = 4'd0; rs3 = 4'd0;

      tbl[0]  = '{4'b0000, 4'd0,  4'd0,  4'd0,  8'h0F, 4'b0000, 1};
      tbl[1]  = '{4'b1010, 4'd7,  4'd0,  4'd0,  8'h09, 4'b0000, 1};
      tbl[2]  = '{4'b1000, 4'd2,  4'd0,  4'd0,  8'h01, 4'b0000, 1};
      tbl[3]  = '{4'b0111, 4'd0,  4'd4,  4'd1,  8'h05, 4'b0000, 1};
      tbl[4]  = '{4'b1001, 4'd0,  4'd4,  4'd1,  8'h00, 4'b1000, 1};
      tbl[5]  = '{4'b1001, 4'd0,  4'd4,  4'd0,  8'h01, 4'b0000, 1};
      tbl[6]  = '{4'b1011, 4'd6,  4'd4,  4'd0,  8'h0A, 4'b0000, 1};
      tbl[7]  = '{4'b1011, 4'd15, 4'd1,  4'd0,  8'h10, 4'b0010, 1};
      tbl[8]  = '{4'b1100, 4'd6,  4'd4,  4'd0,  8'h02, 4'b0000, 1};
      tbl[9]  = '{4'b1100, 4'd2,  4'd4,  4'd0,  8'hFE, 4'b0110, 1};
      tbl[10] = '{4'b1101, 4'd2,  4'd4,  4'd0,  8'h08, 4'b0000, 4};
      tbl[11] = '{4'b1110, 4'd2,  4'd4,  4'd1,  8'h09, 4'b0000, 5};
      tbl[12] = '{4'b1111, 4'd2,  4'd4,  4'd1,  8'h07, 4'b0000, 5};
      tbl[13] = '{4'b1111, 4'd0,  4'd5,  4'd1,  8'hFF, 4'b0110, 5};
      tbl[14] = '{4'b1110, 4'd15, 4'd15, 4'd15, 8'hF0, 4'b0100, 5};
      tbl[15] = '{4'b0011, 4'd0,  4'd0,  4'd0,  8'h00, 4'b1001, 1};

      #12;
      check("rst/in_ready", 32'(in_ready), 32'd1);
      check("rst/out_valid", 32'(out_valid), 32'd0);
      check("rst/result", 32'(result), 32'd0);
      check("rst/status", 32'(status), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c,
               tbl[i].res, tbl[i].st, tbl[i].lat, 0);
      end

      // Backpressure: consumer stalls for 10 cycles in DONE.
      do_op("backpressure", 4'b1101, 4'd3, 4'd5, 4'd0, 8'h0F, 4'b0000, 4, 10);

      // Reset in the middle of a multiply.
      @(negedge clk);
      op = 4'b1101; rs1 = 4'd2; rs2 = 4'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst/out_valid", 32'(out_valid), 32'd0);
      check("midrst/in_ready", 32'(in_ready), 32'd1);
      check("midrst/result", 32'(result), 32'd0);
      check("midrst/status", 32'(status), 32'd0);
      // Accepts offered during reset must be ignored.
      op = 4'b0000; in_valid = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("midrst/no_stale", 32'(out_valid), 32'd0);
      end
      do_op("post_rst", 4'b1101, 4'd3, 4'd3, 4'd0, 8'h09, 4'b0000, 4, 0);

      for (int i = 0; i < 80; i++) begin
         ro = 4'($urandom_range(15));
         ra = 4'($urandom_range(15));
         rb = 4'($urandom_range(15));
         rc = 4'($urandom_range(15));
         model(ro, int'(ra), int'(rb), int'(rc), mr, ms, ml);
         do_op($sformatf("rnd%0d_op%b", i, ro), ro, ra, rb, rc, mr, ms, ml,
               int'($urandom_range(2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
